mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch port and its load/store port. It lets both share one unified memory that has variable latency and a req/ack handshake. At most one transaction is outstanding at a time. Data accesses win by default, and a streak counter guarantees fetch progress. It sits between the core's imem/dmem interfaces and the unified memory model.

## Interface
- `ADDR_W`, default 32: address width, byte address.
- `DATA_W`, default 32: data width.
- `MAX_DATA_STREAK`, default 4: maximum consecutive data grants while a fetch is pending. Range 1..15.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_ireq`  in  1  fetch request.
- `i_iaddr`  in  ADDR_W  fetch address.
- `o_ivalid`  out  1  fetch response, single-cycle pulse.
- `o_irdata`  out  DATA_W  fetch data; valid while `o_ivalid` is high.
- `i_dreq`  in  1  data request.
- `i_dwen`  in  1  1 = store, 0 = load.
- `i_daddr`  in  ADDR_W  data address.
- `i_dwdata`  in  DATA_W  store data.
- `i_dwstrb`  in  DATA_W/8  store byte strobes.
- `o_dvalid`  out  1  data response pulse; for a store it means the write is complete.
- `o_drdata`  out  DATA_W  load data; valid while `o_dvalid` is high, and 0 for stores.
- `o_mem_req`  out  1  memory request.
- `o_mem_wen`  out  1  memory write enable.
- `o_mem_addr`  out  ADDR_W  memory address.
- `o_mem_wdata`  out  DATA_W  memory write data.
- `o_mem_wstrb`  out  DATA_W/8  memory write strobes.
- `i_mem_ack`  in  1  memory completion, single cycle.
- `i_mem_rdata`  in  DATA_W  read data; valid while `i_mem_ack` is high.

## Operation
- **Requester rule:** hold `req` and all fields stable until the matching `valid` pulse. A requester may raise `req` again in the cycle of `valid` or later.
- **FSM states:**
  - IDLE: no grant.
  - BUSY: `o_mem_req` is high, waiting for ack.
  - RESP: response cycle.
- **IDLE:**
  - If either request is high, pick a winner, latch its addr/wdata/wstrb/wen into the `o_mem_*` registers and the source bit, then go to BUSY.
  - Fetch grants force `o_mem_wen` = 0 and `o_mem_wstrb` = 0.
- **Pick rule:**
  - Only `i_dreq` high: data wins.
  - Only `i_ireq` high: fetch wins.
  - Both high: data wins, unless streak == `MAX_DATA_STREAK`, in which case fetch wins.
- **Streak counter:**
  - Increments on each data grant made while `i_ireq` is high.
  - Clears on any fetch grant, or on a data grant made while `i_ireq` is low.
  - Saturates at `MAX_DATA_STREAK`.
- **BUSY:** `o_mem_req` and the fields stay constant. When `i_mem_ack` is high, register `i_mem_rdata` (or 0 for a store) into the selected `o_*rdata`, then go to RESP.
- **RESP:**
  - The selected `o_*valid` is high for exactly this cycle; the other response stays low.
  - `o_mem_req` is 0. Next state is IDLE.
- **Latching rules:**
  - `i_mem_ack` outside BUSY is ignored.
  - `o_*rdata` holds its last value between responses.
  - Request changes during BUSY or RESP are not sampled.

## Timing
- Every output resets to 0; state resets to IDLE and streak to 0.
- Request sampled in IDLE at cycle c:
  - `o_mem_req` goes high at c+1.
  - Ack at cycle a ≥ c+1 gives `valid` at a+1 and IDLE at a+2.
  - Minimum turnaround is 3 cycles per transaction; back-to-back grants come every 3 cycles when ack is immediate.
- `o_mem_req` drops in the cycle after ack (the RESP cycle).
- If both requests arrive in the same IDLE cycle, exactly one is granted. The loser stays pending and is evaluated in the next IDLE.
- Reset mid-transaction:
  - Reset asserted in BUSY drops `o_mem_req`, `o_*valid` and state asynchronously.
  - The memory abandons the request; no response is delivered to either requester after reset.
  - The requester reissues its request after reset.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  - the source encoding: SRC_I = 1'b0, SRC_D = 1'b1;
  - the streak counter width, 4 bits.
- Sub-module `mem_arb_pick`:
  - contains the combinational winner select and the streak counter register;
  - inputs are `i_ireq`, `i_dreq` and a grant strobe;
  - output is the winner source.
- Top level holds the FSM, the latched request registers and the response registers.

## Test plan
- **Single fetch:** after reset, `i_ireq` = 1 and `i_iaddr` = 0x40. Memory acks 2 cycles after `o_mem_req` with rdata 0x00500093. Required: `o_mem_addr` = 0x40 and `o_mem_wen` = 0; one `o_ivalid` pulse with `o_irdata` = 0x00500093; `o_dvalid` stays 0.
- **Store with strobes:** `i_dreq` = 1, `i_dwen` = 1, addr 0x100, wdata 0xDEADBEEF, wstrb 4'b0011, zero-wait ack. Required: the memory sees exactly these values; `o_dvalid` pulses with `o_drdata` = 0; `o_mem_req` is high for exactly 1 cycle.
- **Contention:** `i_ireq` and `i_dreq` are held continuously, `MAX_DATA_STREAK` = 4, immediate ack. Required grant order: D, D, D, D, I, D, D, D, D, I. Fetch never waits more than 4 grants.
- **Stability:** change `i_daddr` from 0x200 to 0x300 while BUSY (protocol violation); ack is delayed 5 cycles. Required: `o_mem_addr` stays 0x200 throughout; a stray `i_mem_ack` in IDLE produces no valid pulse.
- **Reset mid-operation:** assert `i_rst_n` = 0 in the second BUSY cycle of a load. Required: `o_mem_req`, `o_dvalid` and `o_drdata` are 0 immediately; after release the state is IDLE, and a fresh fetch to 0x0 completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Which requester owns the current memory transaction
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // Width of the consecutive-data-grant counter (MAX_DATA_STREAK up to 15)
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests plus the data-streak counter.
// Latency: winner is combinational; streak updates on the grant strobe edge.
// Backpressure: none; the owner only strobes i_grant when it can accept a new transaction.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_grant,
  output src_t o_src
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;

  // Data wins by default; a fetch that has been bypassed MAX_DATA_STREAK times wins next
  always_comb begin
    o_src = SRC_I;
    if (i_dreq && !(i_ireq && (streak == STREAK_MAX))) begin
      o_src = SRC_D;
    end
  end

  // Count data grants that bypass a waiting fetch; any other grant restarts the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      streak <= '0;
    end else if (i_grant) begin
      if ((o_src == SRC_D) && i_ireq) begin
        if (streak != STREAK_MAX) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory between the fetch and load/store ports, one transaction at a time.
// Latency: mem_req one cycle after the request is sampled; valid one cycle after ack; 3-cycle minimum turnaround.
// Backpressure: requesters hold req until their valid pulse; requests are only sampled in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ireq,
  input  logic [ADDR_W-1:0]   i_iaddr,
  output logic                o_ivalid,
  output logic [DATA_W-1:0]   o_irdata,
  input  logic                i_dreq,
  input  logic                i_dwen,
  input  logic [ADDR_W-1:0]   i_daddr,
  input  logic [DATA_W-1:0]   i_dwdata,
  input  logic [DATA_W/8-1:0] i_dwstrb,
  output logic                o_dvalid,
  output logic [DATA_W-1:0]   o_drdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  state_t state;
  src_t   src;
  src_t   win;
  logic   grant;

  // A new transaction starts whenever the arbiter is idle and anyone is asking
  assign grant = (state == IDLE) && (i_ireq || i_dreq);

  mem_arb_pick #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_pick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ireq  (i_ireq),
    .i_dreq  (i_dreq),
    .i_grant (grant),
    .o_src   (win)
  );

  // Transaction FSM: latch the winner's request, wait for ack, deliver one response pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      src         <= SRC_I;
      o_mem_req   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_ivalid    <= 1'b0;
      o_irdata    <= '0;
      o_dvalid    <= 1'b0;
      o_drdata    <= '0;
    end else begin
      o_ivalid <= 1'b0;
      o_dvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            src       <= win;
            o_mem_req <= 1'b1;
            if (win == SRC_D) begin
              o_mem_wen   <= i_dwen;
              o_mem_addr  <= i_daddr;
              o_mem_wdata <= i_dwdata;
              o_mem_wstrb <= i_dwstrb;
            end else begin
              // Fetches are always reads: no write enable, no strobes
              o_mem_wen   <= 1'b0;
              o_mem_addr  <= i_iaddr;
              o_mem_wdata <= '0;
              o_mem_wstrb <= '0;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            if (src == SRC_D) begin
              o_dvalid <= 1'b1;
              o_drdata <= o_mem_wen ? '0 : i_mem_rdata;
            end else begin
              o_ivalid <= 1'b1;
              o_irdata <= i_mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          o_mem_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
